// File: rtl/packConv.sv
// Shared types for the convolution stream adapter: data word, kernel/map/result
// bundles and the adapter state encoding.
package packConv;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned N_WEIGHTS = 9;
    localparam int unsigned N_PIXELS  = 25;
    localparam int unsigned N_RESULTS = 9;
    localparam int unsigned LOAD_LAST = N_WEIGHTS + N_PIXELS - 1;

    typedef logic [DATA_W-1:0]   regC;
    typedef regC [N_WEIGHTS-1:0] param9;
    typedef regC [N_PIXELS-1:0]  param25;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } adapter_state_e;

endpackage

// File: rtl/conv_stream_adapter.sv
// Streams a 3x3 kernel and 5x5 map into a convolution core, launches it, waits
// for its results (with timeout) and streams the 9 results back out.
module conv_stream_adapter
    import packConv::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   in_valid,
    output logic   in_ready,
    input  regC    in_data,
    output logic   start,
    output param25 inputMAP,
    output param9  weights,
    input  param9  outputMAP,
    input  logic   data_valid,
    output logic   out_valid,
    input  logic   out_ready,
    output regC    out_data,
    output logic   out_last,
    output logic   busy,
    output logic   err
);

    localparam int unsigned LOAD_W = 6;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned WIDX_W = 4;
    localparam int unsigned PIDX_W = 5;

    adapter_state_e    state_q, state_d;
    logic [LOAD_W-1:0] load_cnt_q, load_cnt_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    param9             weights_q, weights_d;
    param25            map_q, map_d;
    param9             result_q, result_d;
    logic              in_ready_q, in_ready_d;
    logic              start_q, start_d;
    logic              out_valid_q, out_valid_d;
    regC               out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              in_xfer_c;
    logic              out_xfer_c;
    logic              load_last_c;
    logic              send_last_c;
    logic              timeout_c;
    logic [PIDX_W-1:0] pix_idx_c;

    assign in_xfer_c   = (state_q == ST_LOAD) && in_valid && in_ready_q;
    assign out_xfer_c  = (state_q == ST_SEND) && out_valid_q && out_ready;
    assign load_last_c = (load_cnt_q == LOAD_W'(LOAD_LAST));
    assign send_last_c = (idx_q == IDX_W'(N_RESULTS - 1));
    assign timeout_c   = (state_q == ST_WAIT) && !data_valid &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign pix_idx_c   = PIDX_W'(load_cnt_q - LOAD_W'(N_WEIGHTS));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (in_xfer_c && load_last_c) state_d = ST_START;
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (data_valid) begin
                    state_d = ST_SEND;
                end else if (timeout_c) begin
                    state_d = ST_LOAD;
                end
            end
            ST_SEND:  if (out_xfer_c && send_last_c) state_d = ST_LOAD;
            default:  state_d = ST_LOAD;
        endcase
    end

    // Datapath: frame assembly, timeout counter, result capture, send index
    always_comb begin
        load_cnt_d = load_cnt_q;
        wait_cnt_d = '0;
        idx_d      = idx_q;
        weights_d  = weights_q;
        map_d      = map_q;
        result_d   = result_q;

        if (in_xfer_c) begin
            load_cnt_d = load_last_c ? '0 : load_cnt_q + LOAD_W'(1);
            if (load_cnt_q < LOAD_W'(N_WEIGHTS)) begin
                weights_d[load_cnt_q[WIDX_W-1:0]] = in_data;
            end else begin
                map_d[pix_idx_c] = in_data;
            end
        end

        if (state_q == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
            if (data_valid) begin
                result_d = outputMAP;
            end
        end

        if (out_xfer_c) begin
            idx_d = send_last_c ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Registered outputs, decoded from the upcoming state
    always_comb begin
        in_ready_d  = (state_d == ST_LOAD);
        start_d     = (state_d == ST_START);
        busy_d      = (state_d != ST_LOAD);
        out_valid_d = (state_d == ST_SEND);
        out_data_d  = (state_d == ST_SEND) ? result_d[idx_d] : '0;
        out_last_d  = (state_d == ST_SEND) && (idx_d == IDX_W'(N_RESULTS - 1));
        err_d       = err_q;
        if (timeout_c) begin
            err_d = 1'b1;
        end
        if (state_d == ST_START) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            idx_q       <= '0;
            weights_q   <= '0;
            map_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            idx_q       <= idx_d;
            weights_q   <= weights_d;
            map_q       <= map_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            start_q     <= start_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign start     = start_q;
    assign weights   = weights_q;
    assign inputMAP  = map_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_conv_stream_adapter.sv
// Directed bench for conv_stream_adapter paired with a naive behavioural
// convolution core that can be muted to exercise the timeout path.
module tb_conv_stream_adapter;
    import packConv::*;

    logic   clk = 1'b0;
    logic   reset;
    logic   in_valid;
    logic   in_ready;
    regC    in_data;
    logic   start;
    param25 inputMAP;
    param9  weights;
    param9  outputMAP;
    logic   data_valid;
    logic   out_valid;
    logic   out_ready;
    regC    out_data;
    logic   out_last;
    logic   busy;
    logic   err;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    bit core_en  = 1'b1;

    param9  core_res;
    param9  w_ones, w_center;
    param25 p_ramp;

    int exp_a [9] = '{54, 63, 72, 99, 108, 117, 144, 153, 162};
    int exp_b [9] = '{12, 14, 16, 22, 24, 26, 32, 34, 36};

    always #5 clk = ~clk;

    conv_stream_adapter #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .start      (start),
        .inputMAP   (inputMAP),
        .weights    (weights),
        .outputMAP  (outputMAP),
        .data_valid (data_valid),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Naive core: valid 3x3 convolution, results a few cycles after start,
    // data_valid held on for extra cycles carrying junk after the first.
    initial begin
        data_valid = 1'b0;
        outputMAP  = '0;
        forever begin
            @(negedge clk);
            if (start && core_en && !reset) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        int acc;
                        acc = 0;
                        for (int i = 0; i < 3; i++) begin
                            for (int j = 0; j < 3; j++) begin
                                acc += int'(weights[3*i+j]) * int'(inputMAP[5*(r+i)+c+j]);
                            end
                        end
                        core_res[3*r+c] = 16'(acc);
                    end
                end
                repeat (4) @(negedge clk);
                outputMAP  = core_res;
                data_valid = 1'b1;
                @(negedge clk);
                for (int k = 0; k < 9; k++) outputMAP[k] = 16'hDEAD;
                repeat (2) @(negedge clk);
                data_valid = 1'b0;
            end
        end
    end

    task automatic send_word(input regC d);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic load_frame(input param9 w, input param25 p);
        for (int i = 0; i < 9; i++) send_word(w[i]);
        for (int i = 0; i < 25; i++) send_word(p[i]);
    endtask

    task automatic collect(input int exp [9], input bit stall, input bit hold_in);
        int  n, cyc;
        regC prev_data;
        logic prev_last;
        bit  have_prev;
        n = 0;
        cyc = 0;
        have_prev = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        if (hold_in) begin
            in_valid = 1'b1;
            in_data  = 16'hBEEF;
        end
        while (n < 9 && cyc < 200) begin
            out_ready = stall ? (cyc % 3 == 2) : 1'b1;
            if (hold_in) check("in_ready_low", 32'(in_ready), 32'd0);
            if (out_valid) begin
                if (have_prev) begin
                    check("stall_data", 32'(out_data), 32'(prev_data));
                    check("stall_last", 32'(out_last), 32'(prev_last));
                end
                if (out_ready) begin
                    check($sformatf("res%0d", n), 32'(out_data), 32'(exp[n]));
                    check($sformatf("last%0d", n), 32'(out_last), 32'(n == 8));
                    n++;
                    have_prev = 1'b0;
                end else begin
                    prev_data = out_data;
                    prev_last = out_last;
                    have_prev = 1'b1;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (n < 9) check("results_timeout", 32'(n), 32'd9);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            w_ones[i]   = 16'd1;
            w_center[i] = (i == 4) ? 16'd2 : 16'd0;
        end
        for (int i = 0; i < 25; i++) p_ramp[i] = 16'(i);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_weights", 32'(|weights), 32'd0);
        check("rst_map", 32'(|inputMAP), 32'd0);

        // Frame A, downstream always ready
        load_frame(w_ones, p_ramp);
        check("start_pulse", 32'(start), 32'd1);
        check("start_in_ready", 32'(in_ready), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        check("w8", 32'(weights[8]), 32'd1);
        check("map0", 32'(inputMAP[0]), 32'd0);
        check("map24", 32'(inputMAP[24]), 32'd24);
        @(posedge clk); #1;
        check("start_one_cycle", 32'(start), 32'd0);
        collect(exp_a, 1'b0, 1'b0);
        check("a_back_in_ready", 32'(in_ready), 32'd1);
        check("a_back_busy", 32'(busy), 32'd0);

        // Frame A again, downstream ready one cycle in three
        load_frame(w_ones, p_ramp);
        collect(exp_a, 1'b1, 1'b0);
        check("stall_back_in_ready", 32'(in_ready), 32'd1);

        // Frame B with upstream valid held high through WAIT/SEND
        load_frame(w_center, p_ramp);
        collect(exp_b, 1'b0, 1'b1);
        check("b_w4", 32'(weights[4]), 32'd2);
        check("b_w0", 32'(weights[0]), 32'd0);
        check("b_map24", 32'(inputMAP[24]), 32'd24);

        // Muted core: timeout after 16 WAIT cycles
        core_en = 1'b0;
        load_frame(w_ones, p_ramp);
        n = 0;
        while (!err && n < 40) begin
            @(posedge clk); #1;
            n++;
            check("to_no_out_valid", 32'(out_valid), 32'd0);
        end
        check("to_edges", 32'(n), 32'd17);
        check("to_err", 32'(err), 32'd1);
        check("to_in_ready", 32'(in_ready), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        core_en = 1'b1;

        // err clears on the next launch
        load_frame(w_ones, p_ramp);
        check("err_clr_start", 32'(err), 32'd0);
        collect(exp_a, 1'b0, 1'b0);

        // Reset in the middle of a load, then a clean frame
        for (int i = 0; i < 20; i++) send_word((i < 9) ? w_center[i] : p_ramp[i-9]);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_w4", 32'(weights[4]), 32'd0);
        check("mid_rst_map", 32'(|inputMAP), 32'd0);
        load_frame(w_ones, p_ramp);
        collect(exp_a, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/conv_stream_adapter.md
CONV_STREAM_ADAPTER -- requirements
Module: conv_stream_adapter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles in WAIT before abort.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_ready  output  1  adapter accepts word; transfer = in_valid & in_ready.
REQ-006 in_data  input  $bits(regC)  weight or pixel word.
REQ-007 start  output  1  one-cycle pulse to convolution core.
REQ-008 inputMAP  output  param25  assembled 5x5 map, row-major, index 5*row+col.
REQ-009 weights  output  param9  assembled 3x3 kernel, row-major.
REQ-010 outputMAP  input  param9  core results.
REQ-011 data_valid  input  1  core results ready.
REQ-012 out_valid  output  1  result word valid.
REQ-013 out_ready  input  1  downstream accepts; transfer = out_valid & out_ready.
REQ-014 out_data  output  $bits(regC)  result word.
REQ-015 out_last  output  1  high with result index 8.
REQ-016 busy  output  1  high in every state except LOAD.
REQ-017 err  output  1  sticky timeout flag.

Function
REQ-018 FSM states SHALL be LOAD, START, WAIT, SEND.
REQ-019 LOAD: in_ready=1; words 0..8 SHALL fill weights[0..8], words 9..33 fill inputMAP[0..24]; load counter 0..33.
REQ-020 Transfer of word 33 SHALL move to START next cycle and reset load counter to 0; in_ready=0 outside LOAD.
REQ-021 START SHALL last exactly one cycle with start=1, then WAIT; err cleared in START.
REQ-022 inputMAP and weights SHALL hold stable from START until return to LOAD.
REQ-023 WAIT: first cycle with data_valid=1 SHALL capture all 9 outputMAP entries into result register and move to SEND; further data_valid ignored until next WAIT.
REQ-024 WAIT cycle counter reaching TIMEOUT_CYCLES without data_valid SHALL set err=1, return to LOAD, emit no results.
REQ-025 SEND: out_valid=1, out_data=result[idx], idx starts 0; each transfer increments idx.
REQ-026 out_valid=1 with out_ready=0 SHALL hold out_data, out_last unchanged (no drop, no skip).
REQ-027 Transfer at idx=8 (out_last=1) SHALL return to LOAD; in_ready=1 the following cycle.
REQ-028 Data SHALL pass unmodified; no arithmetic, truncation or sign change on in_data/out_data.
REQ-029 in_valid outside LOAD SHALL be ignored (no capture, no counter change).
REQ-030 data_valid outside WAIT SHALL be ignored.

Reset
REQ-031 reset SHALL force state LOAD, all counters 0, start=0, out_valid=0, out_last=0, busy=0, err=0, in_ready=1 after release.
REQ-032 inputMAP, weights, result register SHALL reset to all zeros.
REQ-033 Reset mid-LOAD/WAIT/SEND SHALL discard partial frame and pending results; first post-reset word is weight 0.

Structure
REQ-034 regC, param9, param25 SHALL come from packConv; add N_WEIGHTS=9, N_PIXELS=25, N_RESULTS=9 and adapter state enum there.
REQ-035 Single module, no sub-module; bench instantiates team's naive convolution core as DUT partner.

Verification
REQ-036 Weights all 1, pixels 0..24, out_ready=1 -> results 54,63,72,99,108,117,144,153,162; out_last on 162 only.
REQ-037 Same frame, out_ready toggled 1-of-3 cycles -> identical 9-value sequence, out_data stable while stalled.
REQ-038 Two back-to-back frames (second: weights 0 except center=2, pixels 0..24) -> second results 12,14,16,22,24,26,32,34,36.
REQ-039 Core replaced by stub never asserting data_valid, TIMEOUT_CYCLES=16 -> err=1 after 16 WAIT cycles, no out_valid, in_ready=1 next cycle.
REQ-040 reset asserted after 20 loaded words, then full frame of REQ-036 -> REQ-036 results exactly.
REQ-041 in_valid held high during WAIT/SEND -> no capture; in_ready=0 throughout.
